// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and byte width.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr_i, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [PW-1:0]   gnt_idx_o,
    output logic            any_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester overwrites the result last.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (PW + 1)'(off);
            if (sum >= (PW + 1)'(NREQ)) begin
                sum = sum - (PW + 1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (req_i[idx]) begin
                gnt_oh_o      = '0;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte sources, round-robin per message,
// keeping multi-byte messages contiguous on the line.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = UART_DW,
    parameter int BUSY_TO = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ack,
    output logic [DW-1:0]      tx_data,
    output logic               tx_start,
    input  logic               tx_ready,
    output logic               busy,
    output logic               err_to
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (BUSY_TO > 0) ? $clog2(BUSY_TO + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TO);

    state_e          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
    logic [PW-1:0]   gnt_idx_q, gnt_idx_d;
    logic            last_q, last_d;
    logic            lock_q, lock_d;
    logic [NREQ-1:0] owner_oh_q, owner_oh_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [DW-1:0]   req_bytes [NREQ];
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] arb_oh;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[i*DW +: DW];
        end
    end

    // While a message is open only its owner may be granted, whatever ptr says.
    assign elig = lock_q ? (req_valid & owner_oh_q) : req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            gnt_oh_q   <= '0;
            gnt_idx_q  <= '0;
            last_q     <= 1'b0;
            lock_q     <= 1'b0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            gnt_oh_q   <= gnt_oh_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            lock_q     <= lock_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        gnt_oh_d   = gnt_oh_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        lock_d     = lock_q;
        owner_oh_d = owner_oh_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (tx_ready && arb_any) begin
                    gnt_oh_d  = arb_oh;
                    gnt_idx_d = arb_idx;
                    data_d    = req_bytes[arb_idx];
                    last_d    = req_last[arb_idx];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!last_q) begin
                    lock_d     = 1'b1;
                    owner_oh_d = gnt_oh_q;
                end else begin
                    lock_d = 1'b0;
                    ptr_d  = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + PW'(1);
                end
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A tx block that never goes busy is treated as having sent the byte.
                if (!tx_ready) begin
                    state_d = WAIT_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_start = (state_q == LAUNCH);
    assign req_ack  = tx_start ? gnt_oh_q : '0;
    assign tx_data  = data_q;
    assign busy     = (state_q != IDLE);
    assign err_to   = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched driving a simple serialising tx block model.
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int BUSY_TO = 15;
    localparam int CPB     = 4;
    localparam int BOUND   = 3000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_last  = '0;
    logic [NREQ-1:0]    req_ack;
    logic [DW-1:0]      tx_data;
    logic               tx_start;
    logic               tx_ready_dut;
    logic               busy;
    logic               err_to;
    logic               stub = 1'b0;

    always #10 clk = ~clk;

    uart_tx_sched #(
        .NREQ    (NREQ),
        .DW      (DW),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready_dut),
        .busy      (busy),
        .err_to    (err_to)
    );

    // tx block model: start bit, 8 data bits LSB first, stop bit, CPB clocks each.
    logic       m_act;
    logic [9:0] m_sh;
    int         m_cnt;
    int         m_bit;
    logic       line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0;
            m_sh  <= '1;
            m_cnt <= 0;
            m_bit <= 0;
        end else if (!m_act) begin
            if (tx_start && !stub) begin
                m_act <= 1'b1;
                m_sh  <= {1'b1, tx_data, 1'b0};
                m_cnt <= 0;
                m_bit <= 0;
            end
        end else if (m_cnt == CPB - 1) begin
            m_cnt <= 0;
            m_sh  <= {1'b1, m_sh[9:1]};
            if (m_bit == 9) m_act <= 1'b0;
            else            m_bit <= m_bit + 1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign line         = m_act ? m_sh[0] : 1'b1;
    assign tx_ready_dut = stub ? 1'b1 : !m_act;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } launch_t;

    launch_t    launch_q[$];
    logic [7:0] line_q[$];
    int         n_chk    = 0;
    int         n_pass   = 0;
    int         rx_cnt   = 0;
    int         ack2_cnt = 0;
    int         last_lat = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] d, input bit on_line);
        launch_t e;
        e.idx  = idx;
        e.data = d;
        launch_q.push_back(e);
        if (on_line) line_q.push_back(d);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic last);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        req_data[i*DW +: DW] = d;
        req_last[i]          = last;
        req_valid[i]         = 1'b1;
        while (!got && n < BOUND) begin
            @(negedge clk);
            n++;
            if (req_ack[i]) got = 1'b1;
        end
        req_valid[i] = 1'b0;
        last_lat     = n;
        chk($sformatf("ack%0d_%0h", i, d), got, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || line_q.size() > 0) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_lineq"}, line_q.size(), 0);
    endtask

    task automatic wait_free(input int cycles);
        int n;
        n = 0;
        while (busy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        repeat (cycles) @(negedge clk);
    endtask

    task automatic monitor();
        launch_t    e;
        logic       r_act;
        int         r_cnt;
        int         k;
        logic [7:0] r_byte;
        r_act  = 1'b0;
        r_cnt  = 0;
        r_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                r_act = 1'b0;
            end else begin
                if (tx_start) begin
                    chk("start_rdy", tx_ready_dut, 1);
                    chk("launch_exp", launch_q.size() > 0, 1);
                    if (launch_q.size() > 0) begin
                        e = launch_q.pop_front();
                        chk("ack_oh", req_ack, 32'd1 << e.idx);
                        chk("tx_data", tx_data, e.data);
                    end
                end
                if (req_ack[2]) ack2_cnt++;
                if (!r_act) begin
                    if (line == 1'b0) begin
                        r_act = 1'b1;
                        r_cnt = 1;
                    end
                end else begin
                    if (r_cnt >= CPB + CPB / 2 && ((r_cnt - CPB / 2) % CPB) == 0) begin
                        k = (r_cnt - CPB / 2) / CPB;
                        if (k <= 8) begin
                            r_byte[k-1] = line;
                        end else begin
                            chk("stop_bit", line, 1);
                            chk("rx_exp", line_q.size() > 0, 1);
                            if (line_q.size() > 0) chk("rx_byte", r_byte, line_q.pop_front());
                            rx_cnt++;
                            r_act = 1'b0;
                        end
                    end
                    r_cnt++;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", tx_start, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_to, 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single byte
        rx0 = rx_cnt;
        expect_byte(0, 8'hA5, 1'b1);
        send(0, 8'hA5, 1'b1);
        chk("t1_lat", last_lat, 1);
        wait_idle("t1");
        chk("t1_rx", rx_cnt - rx0, 1);

        // 2: round-robin from a fresh pointer
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_byte(0, 8'h10, 1'b1);
        expect_byte(1, 8'h11, 1'b1);
        expect_byte(2, 8'h12, 1'b1);
        expect_byte(3, 8'h13, 1'b1);
        expect_byte(0, 8'h40, 1'b1);
        fork
            begin send(0, 8'h10, 1'b1); send(0, 8'h40, 1'b1); end
            send(1, 8'h11, 1'b1);
            send(2, 8'h12, 1'b1);
            send(3, 8'h13, 1'b1);
        join
        wait_idle("t2");

        // 3: locked message from req0 while req1 waits
        expect_byte(0, 8'h5A, 1'b1);
        expect_byte(0, 8'h5B, 1'b1);
        expect_byte(0, 8'h5C, 1'b1);
        expect_byte(1, 8'h11, 1'b1);
        fork
            begin
                send(0, 8'h5A, 1'b0);
                wait_free(3);
                send(0, 8'h5B, 1'b0);
                wait_free(3);
                send(0, 8'h5C, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                send(1, 8'h11, 1'b1);
            end
        join
        wait_idle("t3");

        // 4: tx block that never drops ready
        stub = 1'b1;
        chk("t4_err_pre", err_to, 0);
        expect_byte(2, 8'h77, 1'b0);
        send(2, 8'h77, 1'b1);
        repeat (BUSY_TO + 1) @(negedge clk);
        chk("t4_err_early", err_to, 0);
        @(negedge clk);
        chk("t4_err_set", err_to, 1);
        chk("t4_idle", busy, 0);
        expect_byte(2, 8'h78, 1'b0);
        send(2, 8'h78, 1'b1);
        wait_idle("t4");
        chk("t4_err_sticky", err_to, 1);
        stub = 1'b0;
        @(negedge clk);

        // 5: reset while a data bit is on the line
        expect_byte(2, 8'h99, 1'b1);
        send(2, 8'h99, 1'b0);
        begin
            int n;
            n = 0;
            while (line !== 1'b0 && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            chk("t5_startbit", line, 0);
        end
        repeat (2 * CPB + 1) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t5_start", tx_start, 0);
        chk("t5_ack", req_ack, 0);
        chk("t5_data", tx_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err", err_to, 0);
        chk("t5_line", line, 1);
        line_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_byte(1, 8'h3C, 1'b1);
        expect_byte(3, 8'h3D, 1'b1);
        fork
            send(1, 8'h3C, 1'b1);
            send(3, 8'h3D, 1'b1);
        join
        wait_idle("t5");

        // 6: req2 withdraws before the scheduler returns to IDLE
        ack2_cnt = 0;
        expect_byte(0, 8'h42, 1'b1);
        send(0, 8'h42, 1'b1);
        repeat (2) @(negedge clk);
        req_data[2*DW +: DW] = 8'h66;
        req_last[2]          = 1'b1;
        req_valid[2]         = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_still_busy", busy, 1);
        req_valid[2] = 1'b0;
        wait_idle("t6");
        repeat (5) @(negedge clk);
        chk("t6_ack2", ack2_cnt, 0);
        chk("t6_idle", busy, 0);

        chk("end_launchq", launch_q.size(), 0);
        chk("end_lineq", line_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
